// File: rtl/bnn_acc_seq_pkg.sv
// Shared types for the bit-serial BNN accumulator sequencer.
// ALU op encodings and FSM state encodings.
package bnn_acc_seq_pkg;

  localparam logic ALU_OP_ADD1 = 1'b0;
  localparam logic ALU_OP_SUB1 = 1'b1;

  typedef enum logic [1:0] {
    ACC_ST_IDLE = 2'd0,
    ACC_ST_RUN  = 2'd1,
    ACC_ST_DONE = 2'd2
  } acc_st_e;

endpackage

// File: rtl/bnn_acc_seq_if.sv
// Bus bundle for bnn_acc_seq: input handshake, alu link, output handshake.
// slave = sequencer side, master = upstream/alu/downstream side.
interface bnn_acc_seq_if #(
  parameter int n = 12,
  parameter int K = 16
) ();
  logic         in_valid;
  logic         in_ready;
  logic [K-1:0] in_act;
  logic [K-1:0] in_wgt;
  logic         alu_in_a_lsb;
  logic         alu_op;
  logic [n-1:0] alu_in_b;
  logic [n-1:0] alu_out;
  logic         out_valid;
  logic         out_ready;
  logic [n-1:0] out_data;
  logic         busy;

  modport slave (
    input  in_valid, in_act, in_wgt, alu_out, out_ready,
    output in_ready, alu_in_a_lsb, alu_op, alu_in_b,
    output out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_act, in_wgt, alu_out, out_ready,
    input  in_ready, alu_in_a_lsb, alu_op, alu_in_b,
    input  out_valid, out_data, busy
  );
endinterface

// File: rtl/bnn_acc_seq.sv
// Walks act/wgt LSB-first, driving an external alu and registering its sum.
// Ports: clk, rst_n (async low), bus (slave: in/alu/out handshakes, busy).
module bnn_acc_seq
  import bnn_acc_seq_pkg::*;
#(
  parameter int n  = 12,
  parameter int K  = 16,
  parameter int CW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  bnn_acc_seq_if.slave   bus
);

  acc_st_e       state_q, state_d;
  logic [n-1:0]  acc_q, acc_d;
  logic [K-1:0]  act_q, act_d;
  logic [K-1:0]  wgt_q, wgt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic st_run;
  logic st_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC_ST_IDLE;
      acc_q   <= '0;
      act_q   <= '0;
      wgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      act_q   <= act_d;
      wgt_q   <= wgt_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    act_d   = act_q;
    wgt_d   = wgt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ACC_ST_IDLE: begin
        if (bus.in_valid) begin
          act_d   = bus.in_act;
          wgt_d   = bus.in_wgt;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACC_ST_RUN;
        end
      end
      ACC_ST_RUN: begin
        acc_d = bus.alu_out;
        act_d = act_q >> 1;
        wgt_d = wgt_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(K - 1)) begin
          state_d = ACC_ST_DONE;
        end
      end
      ACC_ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ACC_ST_IDLE;
        end
      end
      default: state_d = ACC_ST_IDLE;
    endcase
  end

  assign st_run  = (state_q == ACC_ST_RUN);
  assign st_done = (state_q == ACC_ST_DONE);

  assign bus.in_ready  = (state_q == ACC_ST_IDLE);
  assign bus.busy      = st_run | st_done;
  assign bus.out_valid = st_done;
  assign bus.out_data  = st_done ? acc_q : '0;

  // Outside RUN the alu sees acc+0, so its output is a harmless no-op.
  assign bus.alu_in_a_lsb = st_run & act_q[0];
  assign bus.alu_op       = (st_run && !wgt_q[0]) ? ALU_OP_SUB1
                                                  : ALU_OP_ADD1;
  assign bus.alu_in_b     = acc_q;

endmodule
